// File: rtl/fetch_mem_if.sv
// Instruction-memory read port: single-word request with a variable-latency
// valid response.
interface fetch_mem_if #(
  parameter int ADDR_W = 16
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_valid;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, reads one word at a time from
// instruction memory and pulses ir_load for the instruction register.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_mem_if.master       mem,
  output logic [15:0]       instr,
  output logic              ir_load,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       hold_data_q, hold_data_d;
  logic              ir_load_q, ir_load_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect outranks both mem_valid and stall in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (!redirect) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect)            state_d = mem.mem_valid ? S_REQ : S_DRAIN;
        else if (mem.mem_valid)  state_d = stall ? S_HOLD : S_REQ;
      end
      S_HOLD: begin
        if (redirect || !stall)  state_d = S_REQ;
      end
      S_DRAIN: begin
        if (!redirect && mem.mem_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    instr_d     = instr_q;
    hold_data_d = hold_data_q;
    ir_load_d   = 1'b0;
    case (state_q)
      S_REQ: begin
        if (redirect) pc_d = redirect_pc;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (mem.mem_valid) begin
          if (stall) begin
            hold_data_d = mem.mem_rdata;
          end else begin
            instr_d   = mem.mem_rdata;
            pc_out_d  = pc_q;
            ir_load_d = 1'b1;
            pc_d      = pc_q + ADDR_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (!stall) begin
          instr_d   = hold_data_q;
          pc_out_d  = pc_q;
          ir_load_d = 1'b1;
          pc_d      = pc_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (redirect) pc_d = redirect_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      pc_out_q    <= '0;
      instr_q     <= '0;
      hold_data_q <= '0;
      ir_load_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc_out_q    <= pc_out_d;
      instr_q     <= instr_d;
      hold_data_q <= hold_data_d;
      ir_load_q   <= ir_load_d;
    end
  end

  // The request strobe is the only output that reacts to inputs in-cycle.
  assign mem.mem_rd_en = (state_q == S_REQ) && !redirect;
  assign mem.mem_addr  = pc_q;
  assign instr         = instr_q;
  assign ir_load       = ir_load_q;
  assign pc_out        = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, randomized run against a
// transaction-level PC model, and a 4-bit wrap/reset sequence.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic        ir_load;
  logic [15:0] pc_out;

  logic        rst4_n, stall4, redirect4;
  logic [3:0]  redirect_pc4;
  logic [15:0] instr4;
  logic        ir_load4;
  logic [3:0]  pc_out4;

  fetch_mem_if #(.ADDR_W(16)) bus16 ();
  fetch_mem_if #(.ADDR_W(4))  bus4 ();

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem(bus16), .instr(instr),
    .ir_load(ir_load), .pc_out(pc_out)
  );

  fetch_unit #(.ADDR_W(4), .RESET_PC(4'hF)) dut4 (
    .clk(clk), .reset(rst4_n), .stall(stall4), .redirect(redirect4),
    .redirect_pc(redirect_pc4), .mem(bus4), .instr(instr4),
    .ir_load(ir_load4), .pc_out(pc_out4)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- memory models: word at addr is addr + 16'h1000 ----------------
  int          lat16    = 1;
  bit          rand_lat = 1'b0;
  bit          pend16   = 1'b0;
  int          cnt16    = 0;
  bit          req16;
  logic [15:0] addr16, req_addr16;

  initial begin
    bus16.mem_valid = 1'b0;
    bus16.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      req16      = rst_n && bus16.mem_rd_en;
      req_addr16 = bus16.mem_addr;
      @(posedge clk);
      #2;
      bus16.mem_valid = 1'b0;
      if (!rst_n) begin
        pend16 = 1'b0;
      end else begin
        if (pend16) begin
          cnt16--;
          if (cnt16 == 0) begin
            bus16.mem_valid = 1'b1;
            bus16.mem_rdata = addr16 + 16'h1000;
            pend16 = 1'b0;
          end
        end
        if (req16) begin
          pend16 = 1'b1;
          addr16 = req_addr16;
          cnt16  = rand_lat ? int'($urandom_range(4, 1)) : lat16;
          cnt16--;
          if (cnt16 == 0) begin
            bus16.mem_valid = 1'b1;
            bus16.mem_rdata = addr16 + 16'h1000;
            pend16 = 1'b0;
          end
        end
      end
    end
  end

  bit         req4;
  logic [3:0] req_addr4;

  initial begin
    bus4.mem_valid = 1'b0;
    bus4.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      req4      = rst4_n && bus4.mem_rd_en;
      req_addr4 = bus4.mem_addr;
      @(posedge clk);
      #2;
      bus4.mem_valid = 1'b0;
      if (rst4_n && req4) begin
        bus4.mem_valid = 1'b1;
        bus4.mem_rdata = {12'h000, req_addr4} + 16'h1000;
      end
    end
  end

  // ---------------- transaction-level reference model / monitor ----------------
  // The next loaded word must come from the address after the last loaded one,
  // unless a redirect was sampled since, in which case it comes from that target.
  typedef struct {
    int          c;
    logic [15:0] pc;
    logic [15:0] ins;
  } ev_t;

  ev_t         events[$];
  bit          mon_en    = 1'b0;
  bit          prev_load = 1'b0;
  logic [15:0] exp_pc    = 16'h0;
  logic [15:0] exp_ins;
  int          loads     = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (ir_load) begin
          events.push_back('{cyc - t0, pc_out, instr});
          loads++;
          exp_ins = exp_pc + 16'h1000;
          check("model pc_out", 32'(pc_out), 32'(exp_pc));
          check("model instr", 32'(instr), 32'(exp_ins));
          check("ir_load back-to-back", 32'(prev_load), 32'd0);
          exp_pc = exp_pc + 16'h1;
        end
        if (bus16.mem_rd_en) begin
          check("request while outstanding", 32'(pend16), 32'd0);
          check("model mem_addr", 32'(bus16.mem_addr), 32'(exp_pc));
        end
        if (redirect) exp_pc = redirect_pc;
        prev_load = ir_load;
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    int          lat;
    int          stall_from;
    int          stall_len;
    int          redir_at;
    logic [15:0] redir_pc;
    int          c0;
    logic [15:0] p0;
    int          c1;
    logic [15:0] p1;
    int          c2;
    logic [15:0] p2;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int id, input vec_t v);
    int          cs[3];
    logic [15:0] ps[3];
    logic [15:0] ins_e;
    cs = '{v.c0, v.c1, v.c2};
    ps = '{v.p0, v.p1, v.p2};
    @(posedge clk);
    #1;
    mon_en   = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    lat16    = v.lat;
    rst_n    = 1'b0;
    #1;
    check("reset ir_load", 32'(ir_load), 32'd0);
    check("reset instr", 32'(instr), 32'd0);
    check("reset pc_out", 32'(pc_out), 32'd0);
    check("reset mem_addr", 32'(bus16.mem_addr), 32'd0);
    check("reset mem_rd_en", 32'(bus16.mem_rd_en), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    events.delete();
    exp_pc    = 16'h0;
    prev_load = 1'b0;
    t0        = cyc;
    rst_n     = 1'b1;
    mon_en    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      stall       = (c >= v.stall_from) && (c < v.stall_from + v.stall_len);
      redirect    = (c == v.redir_at);
      redirect_pc = v.redir_pc;
      @(posedge clk);
      #1;
    end
    stall    = 1'b0;
    redirect = 1'b0;
    mon_en   = 1'b0;
    check("vector load count", 32'(events.size() >= 3), 32'd1);
    if (events.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        ins_e = ps[k] + 16'h1000;
        check("vector load cycle", 32'(events[k].c), 32'(cs[k]));
        check("vector load pc_out", 32'(events[k].pc), 32'(ps[k]));
        check("vector load instr", 32'(events[k].ins), 32'(ins_e));
      end
      $display("vector %0d lat=%0d: loads at cycles %0d,%0d,%0d pc_out %h,%h,%h",
               id, v.lat, events[0].c, events[1].c, events[2].c,
               events[0].pc, events[1].pc, events[2].pc);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    stall        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 16'h0;
    rst4_n       = 1'b0;
    stall4       = 1'b0;
    redirect4    = 1'b0;
    redirect_pc4 = 4'h0;

    // lat, stall_from, stall_len, redir_at, redir_pc, then (cycle, pc_out) x3
    vecs[0] = '{1, 0, 0, -1, 16'h0000, 2, 16'h0000, 4, 16'h0001, 6, 16'h0002};
    vecs[1] = '{3, 0, 0, -1, 16'h0000, 4, 16'h0000, 8, 16'h0001, 12, 16'h0002};
    vecs[2] = '{1, 2, 5, -1, 16'h0000, 2, 16'h0000, 8, 16'h0001, 10, 16'h0002};
    vecs[3] = '{3, 0, 0, 1, 16'h0040, 8, 16'h0040, 12, 16'h0041, 16, 16'h0042};
    vecs[4] = '{1, 0, 0, 1, 16'h0123, 4, 16'h0123, 6, 16'h0124, 8, 16'h0125};
    vecs[5] = '{1, 0, 0, 0, 16'h0200, 3, 16'h0200, 5, 16'h0201, 7, 16'h0202};
    vecs[6] = '{1, 1, 4, 3, 16'h0300, 6, 16'h0300, 8, 16'h0301, 10, 16'h0302};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Randomized run: random latency, stall and redirect against the model.
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    rand_lat = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_pc    = 16'h0;
    prev_load = 1'b0;
    loads     = 0;
    t0        = cyc;
    rst_n     = 1'b1;
    mon_en    = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(3, 0) == 0);
      redirect    = ($urandom_range(15, 0) == 0);
      redirect_pc = 16'($urandom);
      @(posedge clk);
      #1;
    end
    stall    = 1'b0;
    redirect = 1'b0;
    mon_en   = 1'b0;
    check("random run load count", 32'(loads > 100), 32'd1);
    $display("random run: %0d instructions loaded", loads);

    // 4-bit PC: wrap from F to 0, then reset in the middle of a WAIT.
    @(posedge clk);
    #1;
    rst4_n = 1'b1;
    @(negedge clk);
    check("w4 first mem_rd_en", 32'(bus4.mem_rd_en), 32'd1);
    check("w4 first mem_addr", 32'(bus4.mem_addr), 32'hF);
    @(negedge clk);
    @(negedge clk);
    check("w4 load0 ir_load", 32'(ir_load4), 32'd1);
    check("w4 load0 pc_out", 32'(pc_out4), 32'hF);
    check("w4 load0 instr", 32'(instr4), 32'h100F);
    $display("w4 load: pc_out=%h instr=%h", pc_out4, instr4);
    @(negedge clk);
    check("w4 gap ir_load", 32'(ir_load4), 32'd0);
    @(negedge clk);
    check("w4 load1 ir_load", 32'(ir_load4), 32'd1);
    check("w4 load1 pc_out", 32'(pc_out4), 32'h0);
    check("w4 load1 instr", 32'(instr4), 32'h1000);
    $display("w4 load: pc_out=%h instr=%h", pc_out4, instr4);
    @(negedge clk);
    rst4_n = 1'b0;
    #1;
    check("w4 midreset ir_load", 32'(ir_load4), 32'd0);
    check("w4 midreset instr", 32'(instr4), 32'd0);
    check("w4 midreset pc_out", 32'(pc_out4), 32'd0);
    check("w4 midreset mem_addr", 32'(bus4.mem_addr), 32'hF);
    @(negedge clk);
    check("w4 killed ir_load", 32'(ir_load4), 32'd0);
    @(posedge clk);
    #1;
    rst4_n = 1'b1;
    @(negedge clk);
    check("w4 restart mem_rd_en", 32'(bus4.mem_rd_en), 32'd1);
    check("w4 restart mem_addr", 32'(bus4.mem_addr), 32'hF);
    @(negedge clk);
    check("w4 restart no early load", 32'(ir_load4), 32'd0);
    @(negedge clk);
    check("w4 restart ir_load", 32'(ir_load4), 32'd1);
    check("w4 restart pc_out", 32'(pc_out4), 32'hF);
    check("w4 restart instr", 32'(instr4), 32'h100F);
    $display("w4 restart load: pc_out=%h instr=%h", pc_out4, instr4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
